// File: rtl/thermo_pkg.sv
// Shared definitions for the thermometer level reader: default bar and
// level widths, the level type and the qualification FSM states.
package thermo_pkg;

    localparam int WIDTH = 16;
    localparam int POS_W = $clog2(WIDTH + 1);

    typedef logic [POS_W-1:0] level_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2,
        ERR    = 2'd3
    } state_t;

endpackage

// File: rtl/therm_check.sv
// Combinational thermometer decoder: popcount gives the candidate level,
// the code is valid when it equals the packed-from-LSB mask of that many ones.
// Build option THERMO_BUBBLE_CORRECT_EN also accepts a code whose only
// deviation from that mask is one swapped pair of adjacent bits.
module therm_check #(
    parameter int WIDTH = thermo_pkg::WIDTH,
    parameter int POS_W = thermo_pkg::POS_W
) (
    input  logic [WIDTH-1:0] i_samp,
    output logic             o_valid,
    output logic [POS_W-1:0] o_level
);

    logic [POS_W-1:0] w_pop;
    logic [WIDTH-1:0] w_mask;
    logic             w_exact;

    // Count the ones in the sample; this is the level whichever check applies.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + POS_W'(i_samp[i]);
        end
    end

    // Ideal thermometer code for the counted level.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_mask[i] = (i < int'(w_pop));
        end
    end

    assign w_exact = (i_samp == w_mask);
    assign o_level = w_pop;

`ifdef THERMO_BUBBLE_CORRECT_EN
    logic [WIDTH-1:0] w_diff;
    logic             w_swap;

    assign w_diff = i_samp ^ w_mask;

    // Equal popcount means a two-bit adjacent difference is a single swap.
    always_comb begin
        w_swap = 1'b0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (w_diff == (WIDTH'(3) << i)) begin
                w_swap = 1'b1;
            end
        end
    end

    assign o_valid = w_exact | w_swap;
`else
    assign o_valid = w_exact;
`endif

endmodule

// File: rtl/thermo_level_reader.sv
// Thermometer level reader: registers the bar, qualifies each code with a
// contiguity check and a STABLE_CYCLES stability filter, and reports every
// accepted level change as a step pulse and a one-deep event.
// Optional build macro: THERMO_BUBBLE_CORRECT_EN (tolerate one adjacent bubble).
module thermo_level_reader #(
    parameter int WIDTH         = thermo_pkg::WIDTH,
    parameter int POS_W         = thermo_pkg::POS_W,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] therm_in,
    output logic [POS_W-1:0] level,
    output logic             level_valid,
    output logic             step_up,
    output logic             step_down,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [POS_W-1:0] evt_level,
    output logic             evt_ovf,
    output logic             code_err,
    output logic [1:0]       o_dbg_state
);

    import thermo_pkg::*;

    localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [WIDTH-1:0] r_samp;
    logic [WIDTH-1:0] r_prev;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    logic [POS_W-1:0] r_level;
    logic             r_level_valid;
    logic             r_step_up;
    logic             r_step_down;
    logic             r_evt_valid;
    logic [POS_W-1:0] r_evt_level;
    logic             r_evt_ovf;

    logic             w_chk_valid;
    logic [POS_W-1:0] w_chk_level;
    logic             w_same;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_counting;
    logic             w_accept;
    logic             w_changed;
    logic             w_post;
    logic             w_step;
    logic             w_hs;

    therm_check #(
        .WIDTH (WIDTH),
        .POS_W (POS_W)
    ) u_check (
        .i_samp  (r_samp),
        .o_valid (w_chk_valid),
        .o_level (w_chk_level)
    );

    // Sample the bar once and keep the previous sample for the stability compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp <= '0;
            r_prev <= '0;
        end else begin
            r_samp <= therm_in;
            r_prev <= r_samp;
        end
    end

    assign w_same     = (r_samp == r_prev);
    assign w_cnt_next = !w_same ? CNT_W'(1) :
                        (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_counting = enable && w_chk_valid &&
                        ((r_state == SETTLE) || (r_state == LOCKED));
    assign w_accept   = w_counting && (w_cnt_next == CNT_MAX);
    assign w_changed  = (w_chk_level != r_level);
    // The first acceptance after IDLE posts an event but never a step.
    assign w_post     = w_accept && (!r_level_valid || w_changed);
    assign w_step     = w_accept && r_level_valid && w_changed;

    // Qualification FSM and saturating stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (!enable) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= SETTLE;
                    r_cnt   <= '0;
                end
                SETTLE, LOCKED: begin
                    if (!w_chk_valid) begin
                        r_state <= ERR;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_accept) begin
                            r_state <= LOCKED;
                        end
                    end
                end
                ERR: begin
                    if (w_chk_valid) begin
                        r_state <= SETTLE;
                        r_cnt   <= CNT_W'(1);
                    end else begin
                        r_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Accepted level; cleared whenever the reader is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level       <= '0;
            r_level_valid <= 1'b0;
        end else if (!enable) begin
            r_level       <= '0;
            r_level_valid <= 1'b0;
        end else if (w_accept) begin
            r_level       <= w_chk_level;
            r_level_valid <= 1'b1;
        end
    end

    // One-cycle direction pulses for a changed accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_up   <= 1'b0;
            r_step_down <= 1'b0;
        end else begin
            r_step_up   <= w_step && (w_chk_level > r_level);
            r_step_down <= w_step && (w_chk_level < r_level);
        end
    end

    // Event slice. valid/ready: an event transfers on a rising clk edge where
    // evt_valid and evt_ready are both 1; while evt_valid=1 and evt_ready=0
    // evt_level only changes if a newer acceptance overwrites it, which sets
    // the sticky evt_ovf. A transfer in the same cycle as a new post is not a
    // loss, so the new event stays pending with evt_ovf cleared. The slice is
    // not cleared by enable, so a pending event survives a disable.
    assign w_hs = r_evt_valid && evt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_valid <= 1'b0;
            r_evt_level <= '0;
            r_evt_ovf   <= 1'b0;
        end else if (w_post) begin
            r_evt_valid <= 1'b1;
            r_evt_level <= w_chk_level;
            r_evt_ovf   <= r_evt_valid && !evt_ready;
        end else if (w_hs) begin
            r_evt_valid <= 1'b0;
            r_evt_ovf   <= 1'b0;
        end
    end

    assign level       = r_level;
    assign level_valid = r_level_valid;
    assign step_up     = r_step_up;
    assign step_down   = r_step_down;
    assign evt_valid   = r_evt_valid;
    assign evt_level   = r_evt_level;
    assign evt_ovf     = r_evt_ovf;
    assign code_err    = !w_chk_valid;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_thermo_level_reader.sv
// Directed bench for thermo_level_reader: reset checks, a table of held
// codes with hand-computed level/state/pulse/event counts, and hand-written
// sequences for latency, toggling, event overflow, disable and async reset.
module tb_thermo_level_reader;

  localparam int WIDTH = 16;
  localparam int POS_W = 5;

  localparam int ST_IDLE   = 0;
  localparam int ST_SETTLE = 1;
  localparam int ST_LOCKED = 2;
  localparam int ST_ERR    = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [WIDTH-1:0] therm_in;
  logic             evt_ready;
  logic [POS_W-1:0] level;
  logic             level_valid;
  logic             step_up;
  logic             step_down;
  logic             evt_valid;
  logic [POS_W-1:0] evt_level;
  logic             evt_ovf;
  logic             code_err;
  logic [1:0]       dbg_state;

  thermo_level_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .therm_in    (therm_in),
    .level       (level),
    .level_valid (level_valid),
    .step_up     (step_up),
    .step_down   (step_down),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_level   (evt_level),
    .evt_ovf     (evt_ovf),
    .code_err    (code_err),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Pulse and handshake observers: read pre-edge values at each rising edge.
  int cnt_up   = 0;
  int cnt_down = 0;
  int cnt_hs   = 0;
  int last_hs_level = -1;

  always @(posedge clk) begin
    if (step_up)   cnt_up++;
    if (step_down) cnt_down++;
    if (evt_valid && evt_ready) begin
      cnt_hs++;
      last_hs_level = int'(evt_level);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [WIDTH-1:0] therm;
    logic             en;
    int               hold;
    int               lvl;
    int               lv;
    int               err;
    int               st;
    int               ups;
    int               downs;
    int               hs;
  } vec_t;

  vec_t tbl [0:9];

  int up0, dn0, hs0;

  initial begin
    // Table rows run with evt_ready=1 starting from LOCKED at level 3.
    tbl[0] = '{16'h001F, 1'b1, 8,  5, 1, 0, ST_LOCKED, 1, 0, 1};
    tbl[1] = '{16'h0001, 1'b1, 8,  1, 1, 0, ST_LOCKED, 0, 1, 1};
`ifdef THERMO_BUBBLE_CORRECT_EN
    tbl[2] = '{16'h0005, 1'b1, 8,  2, 1, 0, ST_LOCKED, 1, 0, 1};
`else
    tbl[2] = '{16'h0005, 1'b1, 8,  1, 1, 1, ST_ERR,    0, 0, 0};
`endif
    tbl[3] = '{16'h00FF, 1'b1, 8,  8, 1, 0, ST_LOCKED, 1, 0, 1};
    tbl[4] = '{16'hFFFF, 1'b1, 8, 16, 1, 0, ST_LOCKED, 1, 0, 1};
    tbl[5] = '{16'h0000, 1'b1, 8,  0, 1, 0, ST_LOCKED, 0, 1, 1};
    tbl[6] = '{16'h0000, 1'b1, 6,  0, 1, 0, ST_LOCKED, 0, 0, 0};
    tbl[7] = '{16'h0000, 1'b0, 2,  0, 0, 0, ST_IDLE,   0, 0, 0};
    tbl[8] = '{16'h0003, 1'b1, 8,  2, 1, 0, ST_LOCKED, 0, 0, 1};
    tbl[9] = '{16'h8000, 1'b1, 4,  2, 1, 1, ST_ERR,    0, 0, 0};

    // Reset state
    rst_n = 1'b0; enable = 1'b0; therm_in = '0; evt_ready = 1'b0;
    tick(3);
    check("rst_level",       int'(level),       0);
    check("rst_level_valid", int'(level_valid), 0);
    check("rst_evt_valid",   int'(evt_valid),   0);
    check("rst_evt_ovf",     int'(evt_ovf),     0);
    check("rst_code_err",    int'(code_err),    0);
    check("rst_state",       int'(dbg_state),   ST_IDLE);

    // First acceptance: 0x0007 held, no step pulse, event posted
    rst_n = 1'b1; enable = 1'b1; therm_in = 16'h0007;
    up0 = cnt_up; dn0 = cnt_down;
    tick(4);
    check("a_lv_early",  int'(level_valid), 0);
    check("a_state_set", int'(dbg_state),   ST_SETTLE);
    tick(2);
    check("a_level",     int'(level),       3);
    check("a_lv",        int'(level_valid), 1);
    check("a_evt_valid", int'(evt_valid),   1);
    check("a_evt_level", int'(evt_level),   3);
    check("a_state",     int'(dbg_state),   ST_LOCKED);
    check("a_no_step",   (cnt_up - up0) + (cnt_down - dn0), 0);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("a_hs_clear",  int'(evt_valid), 0);
    check("a_hs_level",  last_hs_level,   3);

    // Table of held codes
    evt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      up0 = cnt_up; dn0 = cnt_down; hs0 = cnt_hs;
      therm_in = tbl[i].therm;
      enable   = tbl[i].en;
      tick(tbl[i].hold);
      check($sformatf("t%0d_level", i), int'(level),       tbl[i].lvl);
      check($sformatf("t%0d_lv", i),    int'(level_valid), tbl[i].lv);
      check($sformatf("t%0d_err", i),   int'(code_err),    tbl[i].err);
      check($sformatf("t%0d_state", i), int'(dbg_state),   tbl[i].st);
      check($sformatf("t%0d_ups", i),   cnt_up - up0,      tbl[i].ups);
      check($sformatf("t%0d_downs", i), cnt_down - dn0,    tbl[i].downs);
      check($sformatf("t%0d_hs", i),    cnt_hs - hs0,      tbl[i].hs);
      if (tbl[i].hs > 0)
        check($sformatf("t%0d_hs_level", i), last_hs_level, tbl[i].lvl);
    end

    // Toggling 3/7 never stabilises: level held, no events
    up0 = cnt_up; dn0 = cnt_down; hs0 = cnt_hs;
    for (int i = 0; i < 12; i++) begin
      therm_in = (i % 2 == 0) ? 16'h0003 : 16'h0007;
      tick(1);
    end
    check("tog_level", int'(level),       2);
    check("tog_lv",    int'(level_valid), 1);
    check("tog_state", int'(dbg_state),   ST_SETTLE);
    check("tog_steps", (cnt_up - up0) + (cnt_down - dn0), 0);
    check("tog_hs",    cnt_hs - hs0, 0);
    check("tog_evt",   int'(evt_valid), 0);

    // Overflow: accept 3 then 8 with no consumer
    evt_ready = 1'b0;
    up0 = cnt_up;
    therm_in = 16'h0007;
    tick(8);
    check("ovf_lvl3",      int'(level),     3);
    check("ovf_evt_lvl3",  int'(evt_level), 3);
    check("ovf_valid1",    int'(evt_valid), 1);
    check("ovf_flag0",     int'(evt_ovf),   0);
    therm_in = 16'h00FF;
    tick(8);
    check("ovf_lvl8",      int'(level),     8);
    check("ovf_evt_lvl8",  int'(evt_level), 8);
    check("ovf_valid2",    int'(evt_valid), 1);
    check("ovf_flag1",     int'(evt_ovf),   1);
    check("ovf_ups",       cnt_up - up0,    2);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("ovf_hs_valid",  int'(evt_valid), 0);
    check("ovf_hs_flag",   int'(evt_ovf),   0);
    check("ovf_hs_level",  last_hs_level,   8);

    // Disable mid-settle: count discarded, level cleared, no event
    therm_in = 16'h000F;
    tick(2);
    enable = 1'b0;
    tick(1);
    check("dis_lv",    int'(level_valid), 0);
    check("dis_level", int'(level),       0);
    check("dis_state", int'(dbg_state),   ST_IDLE);
    check("dis_evt",   int'(evt_valid),   0);

    // Pending event survives a disable
    enable = 1'b1;
    up0 = cnt_up;
    tick(8);
    check("re_level",     int'(level),     4);
    check("re_evt_level", int'(evt_level), 4);
    check("re_no_step",   cnt_up - up0,    0);
    enable = 1'b0;
    tick(1);
    check("keep_evt_valid", int'(evt_valid),   1);
    check("keep_evt_level", int'(evt_level),   4);
    check("keep_lv",        int'(level_valid), 0);

    // Asynchronous reset between edges while settling
    enable = 1'b1;
    therm_in = 16'h003F;
    tick(3);
    check("pre_rst_state", int'(dbg_state), ST_SETTLE);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_evt_valid", int'(evt_valid),   0);
    check("arst_evt_level", int'(evt_level),   0);
    check("arst_level",     int'(level),       0);
    check("arst_lv",        int'(level_valid), 0);
    check("arst_state",     int'(dbg_state),   ST_IDLE);
    check("arst_code_err",  int'(code_err),    0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
